// File: rtl/alu16_sequencer_if.sv
// Bundle between the 16-bit sequencer, the instruction decoder / register file,
// and the shared 8-bit ALU + status block.
interface alu16_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        carry_in;
    logic [7:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  flags_out;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic        alu_sub;
    logic [7:0]  alu_result;
    logic        alu_c;
    logic        alu_h;
    logic        alu_pv;
    logic        alu_s;
    logic        alu_z;

    // Sequencer side
    modport slave (
        input  start, op, opa, opb, carry_in, flags_in,
        input  alu_result, alu_c, alu_h, alu_pv, alu_s, alu_z,
        output busy, done, result, flags_out,
        output alu_a, alu_b, alu_cin, alu_sub
    );

    // Decoder / register file / ALU side
    modport master (
        output start, op, opa, opb, carry_in, flags_in,
        output alu_result, alu_c, alu_h, alu_pv, alu_s, alu_z,
        input  busy, done, result, flags_out,
        input  alu_a, alu_b, alu_cin, alu_sub
    );
endinterface

// File: rtl/alu16_sequencer.sv
// Runs the shared byte ALU twice (low byte, then high byte) to execute the
// Z80 ADD/ADC/SBC HL,ss group and composes the 16-bit result and flag byte.
module alu16_sequencer (
    input  logic             clk,
    input  logic             rst_n,
    alu16_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SBC  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    state_t      state;
    logic [1:0]  op_reg;
    logic [7:0]  hi_a;
    logic [7:0]  hi_b;
    logic        keep_s;
    logic        keep_z;
    logic        keep_pv;
    logic [7:0]  lo_result;
    logic        lo_z;
    logic [7:0]  hi_flags;

    // ADD HL,ss preserves S, Z and P/V; the other two ops take them from the word result.
    always_comb begin
        hi_flags = {bus.alu_s, lo_z & bus.alu_z, bus.alu_result[5], bus.alu_h,
                    bus.alu_result[3], bus.alu_pv, op_reg == OP_SBC, bus.alu_c};
        if (op_reg == OP_ADD) begin
            hi_flags[7] = keep_s;
            hi_flags[6] = keep_z;
            hi_flags[2] = keep_pv;
            hi_flags[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_reg        <= 2'd0;
            hi_a          <= 8'd0;
            hi_b          <= 8'd0;
            keep_s        <= 1'b0;
            keep_z        <= 1'b0;
            keep_pv       <= 1'b0;
            lo_result     <= 8'd0;
            lo_z          <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= 16'd0;
            bus.flags_out <= 8'd0;
            bus.alu_a     <= 8'd0;
            bus.alu_b     <= 8'd0;
            bus.alu_cin   <= 1'b0;
            bus.alu_sub   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_reg   <= bus.op;
                        hi_a     <= bus.opa[15:8];
                        hi_b     <= bus.opb[15:8];
                        keep_s   <= bus.flags_in[7];
                        keep_z   <= bus.flags_in[6];
                        keep_pv  <= bus.flags_in[2];
                        bus.busy <= 1'b1;
                        if (bus.op == OP_PASS) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.result    <= bus.opa;
                            bus.flags_out <= bus.flags_in;
                        end else begin
                            state       <= LOW;
                            bus.alu_a   <= bus.opa[7:0];
                            bus.alu_b   <= bus.opb[7:0];
                            bus.alu_cin <= (bus.op != OP_ADD) & bus.carry_in;
                            bus.alu_sub <= (bus.op == OP_SBC);
                        end
                    end
                end
                LOW: begin
                    // Low-byte carry/borrow feeds straight into the high-byte pass.
                    lo_result   <= bus.alu_result;
                    lo_z        <= bus.alu_z;
                    bus.alu_a   <= hi_a;
                    bus.alu_b   <= hi_b;
                    bus.alu_cin <= bus.alu_c;
                    state       <= HIGH;
                end
                HIGH: begin
                    bus.result    <= {bus.alu_result, lo_result};
                    bus.flags_out <= hi_flags;
                    bus.done      <= 1'b1;
                    bus.alu_a     <= 8'd0;
                    bus.alu_b     <= 8'd0;
                    bus.alu_cin   <= 1'b0;
                    bus.alu_sub   <= 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu16_sequencer.sv
// Randomised and directed bench for alu16_sequencer with a byte-ALU environment
// and a word-level reference model checked every cycle.
module tb_alu16_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu16_sequencer_if bus ();
    alu16_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Shared byte ALU + status block (environment)
    logic [8:0] alu_full;
    logic [4:0] alu_nib;
    always_comb begin
        if (bus.alu_sub) begin
            alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, bus.alu_cin};
            alu_nib  = {1'b0, bus.alu_a[3:0]} - {1'b0, bus.alu_b[3:0]} - {4'd0, bus.alu_cin};
        end else begin
            alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
            alu_nib  = {1'b0, bus.alu_a[3:0]} + {1'b0, bus.alu_b[3:0]} + {4'd0, bus.alu_cin};
        end
        bus.alu_result = alu_full[7:0];
        bus.alu_c      = alu_full[8];
        bus.alu_h      = alu_nib[4];
        bus.alu_s      = alu_full[7];
        bus.alu_z      = (alu_full[7:0] == 8'd0);
        if (bus.alu_sub)
            bus.alu_pv = (bus.alu_a[7] != bus.alu_b[7]) && (alu_full[7] != bus.alu_a[7]);
        else
            bus.alu_pv = (bus.alu_a[7] == bus.alu_b[7]) && (alu_full[7] != bus.alu_a[7]);
    end

    // Word-level reference: returns {result, flags}
    function automatic logic [23:0] ref16(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin,
                                          input logic [7:0] fin);
        int ua, ub, c, full, nib, sa, sb, sres;
        logic [15:0] r;
        logic s, z, h, pv, cy;
        if (op == 2'd3) return {a, fin};
        ua = int'(a);
        ub = int'(b);
        c  = (op == 2'd0) ? 0 : int'(cin);
        sa = a[15] ? ua - 65536 : ua;
        sb = b[15] ? ub - 65536 : ub;
        if (op == 2'd2) begin
            full = ua - ub - c;
            nib  = (ua & 'hFFF) - (ub & 'hFFF) - c;
            sres = sa - sb - c;
            cy   = (full < 0);
            h    = (nib < 0);
        end else begin
            full = ua + ub + c;
            nib  = (ua & 'hFFF) + (ub & 'hFFF) + c;
            sres = sa + sb + c;
            cy   = (full > 'hFFFF);
            h    = (nib > 'hFFF);
        end
        r  = full[15:0];
        pv = (sres > 32767) || (sres < -32768);
        s  = r[15];
        z  = (r == 16'd0);
        if (op == 2'd0) begin
            s  = fin[7];
            z  = fin[6];
            pv = fin[2];
        end
        return {r, s, z, r[13], h, r[11], pv, op == 2'd2, cy};
    endfunction

    // Model timeline: m_remain = busy cycles still to come after the latest edge
    int          m_remain = 0;
    int          m_lo;
    int          m_c;
    logic [15:0] m_res = 16'd0;
    logic [7:0]  m_flags = 8'd0;
    logic [15:0] m_pend_res = 16'd0;
    logic [7:0]  m_pend_flags = 8'd0;
    logic [7:0]  m_lo_a = 8'd0, m_lo_b = 8'd0, m_hi_a = 8'd0, m_hi_b = 8'd0;
    logic        m_lo_cin = 1'b0, m_hi_cin = 1'b0, m_sub = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_remain = 0;
            m_res    = 16'd0;
            m_flags  = 8'd0;
        end else begin
            if (m_remain > 0) begin
                m_remain--;
            end else if (bus.start) begin
                {m_pend_res, m_pend_flags} = ref16(bus.op, bus.opa, bus.opb, bus.carry_in, bus.flags_in);
                m_remain = (bus.op == 2'd3) ? 1 : 3;
                m_c      = (bus.op == 2'd0) ? 0 : int'(bus.carry_in);
                m_sub    = (bus.op == 2'd2);
                m_lo_a   = bus.opa[7:0];
                m_lo_b   = bus.opb[7:0];
                m_hi_a   = bus.opa[15:8];
                m_hi_b   = bus.opb[15:8];
                m_lo_cin = (m_c != 0);
                if (m_sub) begin
                    m_lo     = int'(bus.opa[7:0]) - int'(bus.opb[7:0]) - m_c;
                    m_hi_cin = (m_lo < 0);
                end else begin
                    m_lo     = int'(bus.opa[7:0]) + int'(bus.opb[7:0]) + m_c;
                    m_hi_cin = (m_lo > 255);
                end
            end
            if (m_remain == 1) begin
                m_res   = m_pend_res;
                m_flags = m_pend_flags;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", bus.busy, m_remain > 0);
        chk("done", bus.done, m_remain == 1);
        chk("result", bus.result, m_res);
        chk("flags_out", bus.flags_out, m_flags);
        chk("alu_a", bus.alu_a, (m_remain == 3) ? m_lo_a : (m_remain == 2) ? m_hi_a : 8'd0);
        chk("alu_b", bus.alu_b, (m_remain == 3) ? m_lo_b : (m_remain == 2) ? m_hi_b : 8'd0);
        chk("alu_cin", bus.alu_cin, (m_remain == 3) ? m_lo_cin : (m_remain == 2) ? m_hi_cin : 1'b0);
        chk("alu_sub", bus.alu_sub, (m_remain == 3 || m_remain == 2) ? m_sub : 1'b0);
    end

    task automatic wait_idle();
        for (int n = 0; n < 20 && m_remain != 0; n++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic [7:0] fin,
                          input logic [15:0] er, input logic [7:0] ef, input int lat);
        int acc;
        int seen;
        wait_idle();
        bus.op = op; bus.opa = a; bus.opb = b; bus.carry_in = cin; bus.flags_in = fin;
        bus.start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        #1 bus.start = 1'b0;
        seen = -1;
        for (int i = 0; i < 8 && seen < 0; i++) begin
            @(negedge clk);
            if (bus.done) seen = cyc;
        end
        chk({name, "_latency"}, seen - acc, lat);
        chk({name, "_result"}, bus.result, er);
        chk({name, "_flags"}, bus.flags_out, ef);
        $display("op %s: op=%0d a=%h b=%h cin=%0d fin=%h -> result=%h flags=%h", name, op, a, b, cin, fin, bus.result, bus.flags_out);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.start = 1'b0; bus.op = 2'd0; bus.opa = 16'd0; bus.opb = 16'd0;
        bus.carry_in = 1'b0; bus.flags_in = 8'd0;

        chk("model_add", ref16(2'd0, 16'h0FFF, 16'h0001, 1'b0, 8'hC4), 24'h1000D4);
        chk("model_sbc", ref16(2'd2, 16'h0000, 16'h0001, 1'b0, 8'h00), 24'hFFFFBB);

        @(negedge clk);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_result", bus.result, 16'd0);
        chk("reset_flags", bus.flags_out, 8'd0);
        #7 rst_n = 1'b1;

        run_op("add16", 2'd0, 16'h0FFF, 16'h0001, 1'b0, 8'hC4, 16'h1000, 8'hD4, 2);
        run_op("adc16_ovf", 2'd1, 16'h7FFF, 16'h0000, 1'b1, 8'hFF, 16'h8000, 8'h94, 2);
        run_op("sbc16_borrow", 2'd2, 16'h0000, 16'h0001, 1'b0, 8'h00, 16'hFFFF, 8'hBB, 2);
        run_op("sbc16_zero", 2'd2, 16'h1234, 16'h1234, 1'b0, 8'hFF, 16'h0000, 8'h42, 2);
        run_op("adc16_lo_zero", 2'd1, 16'h0100, 16'h0000, 1'b0, 8'h00, 16'h0100, 8'h00, 2);

        // start held high: re-accepted every time IDLE is reached
        wait_idle();
        bus.op = 2'd0; bus.start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #2 bus.opa = pick(); bus.opb = pick(); bus.flags_in = 8'($urandom);
            @(negedge clk);
            if (bus.done) cnt++;
        end
        bus.start = 1'b0;
        chk("hold_done_count", cnt, 3);
        $display("hold: start held 12 cycles -> %0d done pulses", cnt);

        run_op("pass", 2'd3, 16'hBEEF, 16'h1111, 1'b1, 8'h55, 16'hBEEF, 8'h55, 0);

        // asynchronous reset during the HIGH pass
        wait_idle();
        bus.op = 2'd1; bus.opa = 16'hFFFF; bus.opb = 16'h0001; bus.carry_in = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_result", bus.result, 16'd0);
        chk("arst_flags", bus.flags_out, 8'd0);
        chk("arst_alu_a", bus.alu_a, 8'd0);
        chk("arst_alu_b", bus.alu_b, 8'd0);
        chk("arst_alu_cin", bus.alu_cin, 1'b0);
        chk("arst_alu_sub", bus.alu_sub, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("arst_no_done", cnt, 0);
        $display("reset: asserted during HIGH, %0d done pulses after release", cnt);

        // random traffic, including starts that arrive while busy
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #2;
            bus.start    = ($urandom_range(0, 2) != 0);
            bus.op       = 2'($urandom_range(0, 3));
            bus.opa      = pick();
            bus.opb      = pick();
            bus.carry_in = 1'($urandom);
            bus.flags_in = 8'($urandom);
        end
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
